// File: rtl/operand_entry_fsm.sv
// Operand entry front end: synchronises/conditions two push-buttons and loads A/B from sw.
// Optional debounce counter enabled by defining LOADER_DEBOUNCE_EN.
module operand_entry_fsm #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_enter,
    input  logic             btn_op,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             button,
    output logic             valid,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_A   = 2'b00,
        S_B   = 2'b01,
        RDY   = 2'b10,
        S_ILL = 2'b11
    } state_t;

    state_t cur, nxt;

    // Bit 0 carries btn_enter, bit 1 carries btn_op.
    logic [1:0] s1, s2, deb, deb_d, press;
    logic       enter_pulse, op_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            deb_d <= '0;
        end else begin
            s1    <= {btn_op, btn_enter};
            s2    <= s1;
            deb_d <= deb;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);

    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    always_comb deb = s2;
`endif

    always_comb begin
        press       = deb & ~deb_d;
        enter_pulse = press[0];
        op_pulse    = press[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_A;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_A:     if (enter_pulse) nxt = S_B;
            S_B:     if (enter_pulse) nxt = RDY;
            RDY:     if (enter_pulse) nxt = S_B;
            default: nxt = S_A;
        endcase
    end

    always_comb begin
        valid = (cur == RDY);
        state = cur;
    end

    // Operand and op-select registers follow the same edge as the state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A      <= '0;
            B      <= '0;
            button <= 1'b0;
        end else begin
            if (enter_pulse) begin
                if (cur == S_A || cur == RDY) A <= sw;
                else if (cur == S_B)          B <= sw;
            end
            if (op_pulse) button <= ~button;
        end
    end

endmodule

// File: doc/operand_entry_fsm.md
# operand_entry_fsm

Sequential front end for the 4-bit adder/subtractor datapath. It turns raw board switches and two push-buttons into stable operands `A` and `B` and an add/subtract select `button`, sampling each operand on a clean button press. A `valid` flag is raised once both operands are held. Its outputs drive the adder/subtractor inputs `A`, `B` and `button` directly.

## Interface
- `WIDTH`, 4: operand width in bits.
- `DEB_CYCLES`, 16: consecutive stable cycles required to accept a button level change. Must be ≥2. The counter width is `$clog2(DEB_CYCLES)`.

Ports:
- `clk` in 1: single system clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw` in WIDTH: operand switches. Assumed stable around presses; not synchronised.
- `btn_enter` in 1: raw, asynchronous "store operand" push-button.
- `btn_op` in 1: raw, asynchronous "toggle operation" push-button.
- `A` out WIDTH: first operand register.
- `B` out WIDTH: second operand register.
- `button` out 1: operation select (0 = add, 1 = subtract).
- `valid` out 1: high while both operands are loaded (state RDY).
- `state` out 2: current FSM state, for debug LEDs.

## Operation
- **Synchroniser.** Each raw button passes through a 2-flop synchroniser (`s1`, `s2`), reset to 0.
- **Conditioner.** Each button has a conditioner that produces a level `deb`, plus a delayed copy `deb_d`. The press pulse is `deb & ~deb_d`, exactly one cycle wide per press. Releases generate no pulse.
- **Debounce counter** (`LOADER_DEBOUNCE_EN` defined):
  - While `s2 != deb`, the counter increments.
  - While `s2 == deb`, the counter clears to 0.
  - When the counter equals `DEB_CYCLES-1` and `s2 != deb`, `deb <= s2` and the counter clears.
  - A bounce shorter than `DEB_CYCLES` cycles therefore restarts the count and yields no pulse.
- **FSM** (`state` encoding):
  - S_A = 2'b00: on `enter_pulse`, `A <= sw`, go to S_B.
  - S_B = 2'b01: on `enter_pulse`, `B <= sw`, go to RDY.
  - RDY = 2'b10: on `enter_pulse`, `A <= sw`, go to S_B. `B` holds its old value until reloaded.
  - 2'b11 is illegal and recovers to S_A on the next edge, with `A`/`B` unchanged.
- **Valid flag.** `valid = (state == RDY)`, decoded combinationally from the state register.
- **Operation toggle.** `op_pulse` toggles `button` in every state. It never changes `state`, `A` or `B`.
- **Simultaneous events.** `enter_pulse` and `op_pulse` in the same cycle both take effect on the same edge.
- **Width rule.** Operands are captured verbatim. There is no arithmetic, extension or saturation.

## Timing
- **Reset values.** Asynchronous reset forces:
  - `A=0`, `B=0`, `button=0`, `valid=0`, `state=S_A`;
  - all `s1`/`s2`/`deb`/`deb_d` = 0 and all counters = 0.
- **Reset mid-operation.** Reset aborts any partial entry or count. A button still held when `rst_n` rises produces a pulse after the normal latency, because `deb` restarts from 0.
- **Press latency.** Let edge N be the first edge that samples a raw button high into `s1`.
  - With debounce: `deb` rises at edge N+DEB_CYCLES+1, the pulse is high during the following cycle, and the register/state update is visible after edge N+DEB_CYCLES+2.
  - Without debounce: the update is visible after edge N+2.
- **Held button.** A button held indefinitely gives exactly one pulse. A second pulse requires a release to be accepted by the conditioner first.
- **Output stability.** Outputs change only on clock edges; `valid` is the only combinational decode.

## Configuration
- Macro `LOADER_DEBOUNCE_EN`.
- **Defined:** the debounce counter is present as described, and `DEB_CYCLES` is honoured.
- **Undefined:** `deb = s2` directly, no counter logic is synthesised, and `DEB_CYCLES` is ignored. Press latency is 2 edges, and every synchronised bounce edge produces a pulse.

## Test plan
All scenarios use `DEB_CYCLES=4` with the macro defined, unless noted.
1. **Reset.** Assert `rst_n=0` mid-count with `btn_enter` high → `A=0`, `B=0`, `button=0`, `valid=0`, `state=00` immediately, without waiting for a clock.
2. **Full entry.** `sw=10`, press `btn_enter` for 10 cycles; `sw=15`, press again → `A=10` visible after edge N+6 of the first press, then `B=15`, `state=10`, `valid=1`.
3. **Bounce rejection.** `btn_enter` toggles high/low every 2 cycles for 12 cycles, then stays low → no pulse; `state` and `A` unchanged.
4. **Operation toggle.** In RDY with `A=1`, `B=4`, press `btn_op` twice (separated by release) → `button` goes 0→1→0; `valid` stays 1 and `A`/`B` are unchanged.
5. **Simultaneous and reload.** In RDY, press `btn_enter` and `btn_op` on the same cycle with `sw=7` → on one edge `A=7`, `button` toggles, `state=01`, `valid=0`; `B` holds 4.
6. **Macro undefined.** A single-cycle clean press with `sw=3` in S_A → `A=3` after edge N+2; a 3-pulse bounce yields three state advances (S_A→S_B→RDY→S_B).
